design_sel_ctrl: RTL and testbench

DESIGN_SEL_CTRL -- requirements
Module: design_sel_ctrl

---
 rtl/design_sel_ctrl_if.sv | 23 ++
 rtl/design_sel_ctrl.sv | 170 +++++++++++++++++
 tb/tb_design_sel_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/design_sel_ctrl_if.sv
// Select/status bundle between the design-select controller (slave side)
// and whatever drives the pad select and consumes the design enables (master side).
interface design_sel_ctrl_if;
  logic [4:0]  design_sel_in;
  logic        lock;
  logic        soft_rst_req;
  logic [4:0]  sel_q;
  logic [31:0] design_onehot;
  logic        design_rst;
  logic        io_gate;
  logic        running;
  logic        sel_valid;

  modport master (
    output design_sel_in, lock, soft_rst_req,
    input  sel_q, design_onehot, design_rst, io_gate, running, sel_valid
  );

  modport slave (
    input  design_sel_in, lock, soft_rst_req,
    output sel_q, design_onehot, design_rst, io_gate, running, sel_valid
  );
endinterface

// File: rtl/design_sel_ctrl.sv
// Design-select controller: debounces an asynchronous pad select, switches the
// active design under reset, and gates the pads until the new design has settled.
module design_sel_ctrl #(
  parameter int NUM_DESIGNS     = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             RESET,
  design_sel_ctrl_if.slave bus
);

  localparam int              DW        = $clog2(DEBOUNCE_CYCLES);
  localparam int              SW        = $clog2(SETTLE_CYCLES);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]   SET_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [5:0]      NUM_LIMIT = 6'(NUM_DESIGNS);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_SWITCH   = 3'd2,
    S_SETTLE   = 3'd3,
    S_RUN      = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [4:0]     sel_q, sel_d;
  logic [31:0]    design_onehot_q, design_onehot_d;
  logic           design_rst_q, design_rst_d;
  logic           io_gate_q, io_gate_d;
  logic           running_q, running_d;

  logic [4:0]     sync_meta_q;
  logic [4:0]     sync_q;
  logic [4:0]     sync_prev_q;
  logic           sync_changed_s;
  logic           sync_in_range_s;
  logic           sel_valid_s;

  // Two-flop synchronizer plus a history stage for the debounce compare; no reset on this data path
  always_ff @(posedge clk) begin
    sync_meta_q <= bus.design_sel_in;
    sync_q      <= sync_meta_q;
    sync_prev_q <= sync_q;
  end

  assign sync_changed_s  = (sync_q != sync_prev_q);
  assign sync_in_range_s = ({1'b0, sync_q} < NUM_LIMIT);
  assign sel_valid_s     = ({1'b0, sel_q} < NUM_LIMIT);

  // Next-state and next-output logic for the select FSM
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    sel_d           = sel_q;
    design_onehot_d = design_onehot_q;
    design_rst_d    = design_rst_q;
    io_gate_d       = io_gate_q;
    running_d       = running_q;

    case (state_q)
      S_HOLD: begin
        deb_cnt_d = '0;
        state_d   = S_DEBOUNCE;
      end

      S_DEBOUNCE: begin
        if (sync_changed_s) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          state_d   = S_SWITCH;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end

      S_SWITCH: begin
        sel_d        = sync_q;
        if (sync_in_range_s) begin
          design_onehot_d = 32'd1 << sync_q;
        end else begin
          design_onehot_d = 32'd0;
        end
        design_rst_d = 1'b1;
        io_gate_d    = 1'b1;
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_cnt_q == SET_LAST) begin
          settle_cnt_d = '0;
          design_rst_d = 1'b0;
          running_d    = 1'b1;
          // An out-of-range selection runs with the pads still tri-stated
          io_gate_d    = ~sel_valid_s;
          state_d      = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end

      S_RUN: begin
        // A new selection takes priority over a soft reset request in the same cycle
        if (!bus.lock && (sync_q != sel_q)) begin
          design_rst_d    = 1'b1;
          io_gate_d       = 1'b1;
          running_d       = 1'b0;
          design_onehot_d = 32'd0;
          deb_cnt_d       = '0;
          state_d         = S_DEBOUNCE;
        end else if (bus.soft_rst_req) begin
          design_rst_d = 1'b1;
          io_gate_d    = 1'b1;
          running_d    = 1'b0;
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        deb_cnt_d       = '0;
        settle_cnt_d    = '0;
        design_onehot_d = 32'd0;
        design_rst_d    = 1'b1;
        io_gate_d       = 1'b1;
        running_d       = 1'b0;
        state_d         = S_HOLD;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q         <= S_HOLD;
      deb_cnt_q       <= '0;
      settle_cnt_q    <= '0;
      sel_q           <= 5'd0;
      design_onehot_q <= 32'd0;
      design_rst_q    <= 1'b1;
      io_gate_q       <= 1'b1;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      sel_q           <= sel_d;
      design_onehot_q <= design_onehot_d;
      design_rst_q    <= design_rst_d;
      io_gate_q       <= io_gate_d;
      running_q       <= running_d;
    end
  end

  assign bus.sel_q         = sel_q;
  assign bus.design_onehot = design_onehot_q;
  assign bus.design_rst    = design_rst_q;
  assign bus.io_gate       = io_gate_q;
  assign bus.running       = running_q;
  assign bus.sel_valid     = sel_valid_s;

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Self-checking bench for design_sel_ctrl: expected run-entry results are queued
// as stimulus is applied and compared when the controller raises running.
module tb_design_sel_ctrl;

  typedef struct packed {
    logic [7:0]  edges;
    logic [4:0]  sel;
    logic [31:0] onehot;
    logic        io_gate;
    logic        valid;
  } exp_t;

  logic  clk = 1'b0;
  logic  RESET;
  int    vec_cnt = 0;
  int    err_cnt = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  design_sel_ctrl_if bus_a();
  design_sel_ctrl_if bus_b();

  design_sel_ctrl dut_a (.clk(clk), .RESET(RESET), .bus(bus_a));
  design_sel_ctrl #(.NUM_DESIGNS(20)) dut_b (.clk(clk), .RESET(RESET), .bus(bus_b));

  assign bus_b.design_sel_in = bus_a.design_sel_in;
  assign bus_b.lock          = bus_a.lock;
  assign bus_b.soft_rst_req  = bus_a.soft_rst_req;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input int edges, input logic [4:0] sel,
                          input logic io_gate, input logic valid);
    exp_t e;
    e.edges   = 8'(edges);
    e.sel     = sel;
    e.onehot  = valid ? (32'd1 << sel) : 32'd0;
    e.io_gate = io_gate;
    e.valid   = valid;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Count edges until running rises on dut_a, then compare against the queued expectation
  task automatic wait_run(input int budget);
    exp_t  e;
    string t;
    int    n;
    bit    seen;
    bit    glitch;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n = 0; seen = 1'b0; glitch = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (bus_a.running) seen = 1'b1;
      else if (!bus_a.design_rst || !bus_a.io_gate) glitch = 1'b1;
    end
    if (!seen) begin
      check_val({t, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_val({t, "_edges"},  32'(n), 32'(e.edges));
    check_val({t, "_sel"},    32'(bus_a.sel_q), 32'(e.sel));
    check_val({t, "_onehot"}, bus_a.design_onehot, e.onehot);
    check_val({t, "_iogate"}, 32'(bus_a.io_gate), 32'(e.io_gate));
    check_val({t, "_valid"},  32'(bus_a.sel_valid), 32'(e.valid));
    check_val({t, "_drst"},   32'(bus_a.design_rst), 32'd0);
    check_val({t, "_held"},   32'(glitch), 32'd0);
  endtask

  initial begin
    bit moved;
    bit saw;
    logic [4:0] pad;

    // Power-on: select 24 stable, reset for four clocks
    RESET = 1'b1;
    bus_a.design_sel_in = 5'd24;
    bus_a.lock = 1'b0;
    bus_a.soft_rst_req = 1'b0;
    repeat (4) tick();
    check_val("rst_sel",    32'(bus_a.sel_q), 32'd0);
    check_val("rst_onehot", bus_a.design_onehot, 32'd0);
    check_val("rst_drst",   32'(bus_a.design_rst), 32'd1);
    check_val("rst_iogate", 32'(bus_a.io_gate), 32'd1);
    check_val("rst_run",    32'(bus_a.running), 32'd0);
    RESET = 1'b0;
    push_exp("boot", 26, 5'd24, 1'b0, 1'b1);
    wait_run(60);
    check_val("boot_onehot_abs", bus_a.design_onehot, 32'h0100_0000);

    // Same pad value on a 20-design instance: runs but stays gated and disabled
    check_val("n20_run",    32'(bus_b.running), 32'd1);
    check_val("n20_valid",  32'(bus_b.sel_valid), 32'd0);
    check_val("n20_onehot", bus_b.design_onehot, 32'd0);
    check_val("n20_iogate", 32'(bus_b.io_gate), 32'd1);
    check_val("n20_drst",   32'(bus_b.design_rst), 32'd0);
    check_val("n20_sel",    32'(bus_b.sel_q), 32'd24);

    // Locked: pad change to 3 is ignored
    bus_a.lock = 1'b1;
    bus_a.design_sel_in = 5'd3;
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_a.sel_q != 5'd24 || !bus_a.running || bus_a.design_rst) moved = 1'b1;
    end
    check_val("lock_hold", 32'(moved), 32'd0);
    check_val("lock_sel",  32'(bus_a.sel_q), 32'd24);

    // Unlock: reselect starts on the next edge
    bus_a.lock = 1'b0;
    tick();
    check_val("unlk_drst",   32'(bus_a.design_rst), 32'd1);
    check_val("unlk_iogate", 32'(bus_a.io_gate), 32'd1);
    check_val("unlk_run",    32'(bus_a.running), 32'd0);
    check_val("unlk_onehot", bus_a.design_onehot, 32'd0);
    check_val("unlk_sel",    32'(bus_a.sel_q), 32'd24);
    // A soft reset request during debounce must not disturb the timing
    bus_a.soft_rst_req = 1'b1;
    tick();
    bus_a.soft_rst_req = 1'b0;
    push_exp("unlk", 24, 5'd3, 1'b0, 1'b1);
    wait_run(60);

    // Soft reset in RUN: eight cycles of design reset, selection kept
    bus_a.soft_rst_req = 1'b1;
    tick();
    bus_a.soft_rst_req = 1'b0;
    check_val("srst_drst",   32'(bus_a.design_rst), 32'd1);
    check_val("srst_iogate", 32'(bus_a.io_gate), 32'd1);
    check_val("srst_run",    32'(bus_a.running), 32'd0);
    check_val("srst_onehot", bus_a.design_onehot, 32'h0000_0008);
    push_exp("srst", 8, 5'd3, 1'b0, 1'b1);
    wait_run(30);

    // Select change and soft reset seen on the same edge: select change wins
    bus_a.design_sel_in = 5'd24;
    tick();
    tick();
    bus_a.soft_rst_req = 1'b1;
    tick();
    bus_a.soft_rst_req = 1'b0;
    check_val("both_onehot", bus_a.design_onehot, 32'd0);
    check_val("both_drst",   32'(bus_a.design_rst), 32'd1);
    push_exp("both", 25, 5'd24, 1'b0, 1'b1);
    wait_run(60);

    // Bouncing pad from reset: 24<->25 every 5 clocks, ends on 25
    RESET = 1'b1;
    pad = 5'd25;
    bus_a.design_sel_in = pad;
    repeat (4) tick();
    RESET = 1'b0;
    saw = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus_a.running || !bus_a.design_rst || bus_a.sel_q != 5'd0) saw = 1'b1;
      if (i % 5 == 0) begin
        pad = (pad == 5'd24) ? 5'd25 : 5'd24;
        bus_a.design_sel_in = pad;
      end
    end
    check_val("tog_noswitch", 32'(saw), 32'd0);
    check_val("tog_lastpad",  32'(bus_a.design_sel_in), 32'd25);
    // 2 synchronizer edges, 1 detect edge, then 16 debounce + 1 switch + 8 settle
    push_exp("tog", 28, 5'd25, 1'b0, 1'b1);
    wait_run(60);

    // Asynchronous reset in the middle of SETTLE, between clock edges
    bus_a.soft_rst_req = 1'b1;
    tick();
    bus_a.soft_rst_req = 1'b0;
    repeat (3) tick();
    check_val("mid_pre_sel", 32'(bus_a.sel_q), 32'd25);
    #2;
    RESET = 1'b1;
    #1;
    check_val("mid_sel",    32'(bus_a.sel_q), 32'd0);
    check_val("mid_onehot", bus_a.design_onehot, 32'd0);
    check_val("mid_drst",   32'(bus_a.design_rst), 32'd1);
    check_val("mid_iogate", 32'(bus_a.io_gate), 32'd1);
    check_val("mid_run",    32'(bus_a.running), 32'd0);
    check_val("mid_b_sel",  32'(bus_b.sel_q), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
